// File: rtl/anubis_pkg.sv
// Shared definitions for the Anubis round-constant sequencer: sizes, FSM encoding and the
// leading part of the Anubis S-box that round constants are drawn from.
package anubis_pkg;

   localparam int unsigned ANUBIS_NUM_ROUNDS_128 = 12;
   localparam int unsigned RC_WIDTH              = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } rc_state_e;

   // Only S[0..59] is ever addressed (r <= 15, j <= 3).
   localparam logic [7:0] ANUBIS_SBOX [60] = '{
      8'ha7, 8'hd3, 8'he6, 8'h71, 8'hd0, 8'hac, 8'h4d, 8'h79,
      8'h3a, 8'hc9, 8'h91, 8'hfc, 8'h1e, 8'h47, 8'h54, 8'hbd,
      8'h8c, 8'ha5, 8'h7a, 8'hfb, 8'h63, 8'hb8, 8'hdd, 8'hd4,
      8'he5, 8'hb3, 8'hc5, 8'hbe, 8'ha9, 8'h88, 8'h0c, 8'ha2,
      8'h39, 8'hdf, 8'h29, 8'hda, 8'h2b, 8'ha8, 8'hcb, 8'h4c,
      8'h4b, 8'h22, 8'haa, 8'h24, 8'h41, 8'h70, 8'ha6, 8'hf9,
      8'h5a, 8'he2, 8'hb0, 8'h36, 8'h7d, 8'he4, 8'h33, 8'hff,
      8'h60, 8'h20, 8'h08, 8'h8b
   };

   // S-box lookup; indices past the stored range read as zero.
   function automatic logic [7:0] anubis_sbox(input logic [7:0] idx);
      logic [7:0] s;
      s = 8'h00;
      if (idx < 8'd60) s = ANUBIS_SBOX[idx[5:0]];
      return s;
   endfunction

endpackage

// File: rtl/anubis_rc_sequencer_round_constants.sv
// Combinational Anubis round constant c^r: top word is S[4(r-1)+0..3], rest zero.
// Round 0 yields an all-zero constant so the idle value falls out naturally.
module Round_Constants
   import anubis_pkg::*;
(
   input  logic [3:0]          round_idx,
   output logic [RC_WIDTH-1:0] rc
);

   logic [7:0] base;

   // Build the four constant bytes from the S-box starting at 4*(r-1).
   always_comb begin
      rc   = '0;
      base = {2'b00, round_idx, 2'b00} - 8'd4;
      if (round_idx != 4'd0) begin
         rc[127:120] = anubis_sbox(base);
         rc[119:112] = anubis_sbox(base + 8'd1);
         rc[111:104] = anubis_sbox(base + 8'd2);
         rc[103:96]  = anubis_sbox(base + 8'd3);
      end
   end

endmodule

// File: rtl/anubis_rc_sequencer.sv
// Steps rounds 1..NUM_ROUNDS after start, presenting each round constant on a
// valid/ready port, then pulses done. abort or reset returns everything to idle.
module anubis_rc_sequencer
   import anubis_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = ANUBIS_NUM_ROUNDS_128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic                rc_ready,
   output logic                rc_valid,
   output logic [RC_WIDTH-1:0] rc_out,
   output logic [3:0]          round_idx,
   output logic                last_round,
   output logic                busy,
   output logic                done
);

   if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_num_rounds
      $error("anubis_rc_sequencer: NUM_ROUNDS must be in 1..15");
   end

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   rc_state_e           state_q, state_d;
   logic [3:0]          round_q, round_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                last_q, last_d;
   logic [RC_WIDTH-1:0] rc_q, rc_next;

   // Constant is computed from the next index so rc_out lines up with round_idx.
   Round_Constants u_round_constants (
      .round_idx (round_d),
      .rc        (rc_next)
   );

   // Next-state and next-output decode; abort always wins over start and handshakes.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_RUN;
               round_d = 4'd1;
               valid_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               round_d = 4'd0;
               valid_d = 1'b0;
            end else if (valid_q && rc_ready) begin
               if (round_q >= LAST_IDX) begin
                  state_d = ST_DONE;
                  round_d = 4'd0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            round_d = 4'd0;
            valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      last_d = valid_d && (round_d == LAST_IDX);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         round_q <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         last_q  <= 1'b0;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         rc_q    <= rc_next;
      end
   end

   assign rc_valid   = valid_q;
   assign rc_out     = rc_q;
   assign round_idx  = round_q;
   assign last_round = last_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_anubis_rc_sequencer.sv
// Directed bench for anubis_rc_sequencer: default 12 rounds plus 1- and 15-round instances.
module tb_anubis_rc_sequencer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0, abort = 1'b0, rc_ready = 1'b0;
   logic         rc_valid, last_round, busy, done;
   logic [127:0] rc_out;
   logic [3:0]   round_idx;

   logic         start1 = 1'b0, ready1 = 1'b0;
   logic         valid1, last1, busy1, done1;
   logic [127:0] rc1;
   logic [3:0]   round1;

   logic         start15 = 1'b0, ready15 = 1'b0;
   logic         valid15, last15, busy15, done15;
   logic [127:0] rc15;
   logic [3:0]   round15;

   logic         abort_off = 1'b0;

   int nchk = 0;
   int nfail = 0;
   int hs_cnt = 0;
   int done_cnt = 0;

   logic [7:0] sb [0:59] = '{
      8'ha7, 8'hd3, 8'he6, 8'h71, 8'hd0, 8'hac, 8'h4d, 8'h79, 8'h3a, 8'hc9, 8'h91, 8'hfc,
      8'h1e, 8'h47, 8'h54, 8'hbd, 8'h8c, 8'ha5, 8'h7a, 8'hfb, 8'h63, 8'hb8, 8'hdd, 8'hd4,
      8'he5, 8'hb3, 8'hc5, 8'hbe, 8'ha9, 8'h88, 8'h0c, 8'ha2, 8'h39, 8'hdf, 8'h29, 8'hda,
      8'h2b, 8'ha8, 8'hcb, 8'h4c, 8'h4b, 8'h22, 8'haa, 8'h24, 8'h41, 8'h70, 8'ha6, 8'hf9,
      8'h5a, 8'he2, 8'hb0, 8'h36, 8'h7d, 8'he4, 8'h33, 8'hff, 8'h60, 8'h20, 8'h08, 8'h8b
   };

   anubis_rc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rc_ready(rc_ready),
      .rc_valid(rc_valid), .rc_out(rc_out), .round_idx(round_idx),
      .last_round(last_round), .busy(busy), .done(done)
   );

   anubis_rc_sequencer #(.NUM_ROUNDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort_off), .rc_ready(ready1),
      .rc_valid(valid1), .rc_out(rc1), .round_idx(round1),
      .last_round(last1), .busy(busy1), .done(done1)
   );

   anubis_rc_sequencer #(.NUM_ROUNDS(15)) dut15 (
      .clk(clk), .rst_n(rst_n), .start(start15), .abort(abort_off), .rc_ready(ready15),
      .rc_valid(valid15), .rc_out(rc15), .round_idx(round15),
      .last_round(last15), .busy(busy15), .done(done15)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] exp_rc(input int r);
      return {sb[4*r-4], sb[4*r-3], sb[4*r-2], sb[4*r-1], 96'h0};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; counts handshakes on the edge and done pulses after it.
   task automatic tick();
      if (rc_valid === 1'b1 && rc_ready === 1'b1) hs_cnt++;
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
   endtask

   initial begin
      // Reset values
      rc_ready = 1'b1;
      #12;
      chk("rst_valid", rc_valid, 0);
      chk("rst_round", round_idx, 0);
      chk("rst_rc", rc_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_last", last_round, 0);
      rst_n = 1'b1;
      tick();

      // 1: full run, ready held high
      start = 1'b1; tick(); start = 1'b0;
      chk("t1_rc1", rc_out, 128'ha7d3e671_00000000_00000000_00000000);
      for (int r = 1; r <= 12; r++) begin
         chk($sformatf("t1_round%0d", r), round_idx, r);
         chk($sformatf("t1_rc%0d", r), rc_out, exp_rc(r));
         chk($sformatf("t1_valid%0d", r), rc_valid, 1);
         chk($sformatf("t1_last%0d", r), last_round, (r == 12));
         tick();
      end
      chk("t1_done", done, 1);
      chk("t1_valid_off", rc_valid, 0);
      chk("t1_round0", round_idx, 0);
      chk("t1_rc0", rc_out, 0);
      chk("t1_busy_done", busy, 1);
      tick();
      chk("t1_done_clr", done, 0);
      chk("t1_busy_clr", busy, 0);

      // 2: backpressure at r=2
      start = 1'b1; tick(); start = 1'b0;
      tick();
      rc_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t2_hold_valid%0d", i), rc_valid, 1);
         chk($sformatf("t2_hold_rc%0d", i), rc_out, 128'hd0ac4d79_00000000_00000000_00000000);
         chk($sformatf("t2_hold_round%0d", i), round_idx, 2);
      end
      rc_ready = 1'b1;
      tick();
      chk("t2_round3", round_idx, 3);
      chk("t2_rc3", rc_out, 128'h3ac991fc_00000000_00000000_00000000);
      for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
      chk("t2_done", done, 1);
      tick();

      // 3: abort at r=5 coincident with a handshake
      start = 1'b1; tick(); start = 1'b0;
      repeat (4) tick();
      chk("t3_round5", round_idx, 5);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t3_valid", rc_valid, 0);
      chk("t3_round", round_idx, 0);
      chk("t3_rc", rc_out, 0);
      chk("t3_busy", busy, 0);
      chk("t3_done", done, 0);
      chk("t3_last", last_round, 0);
      tick();
      chk("t3_nodone", done, 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("t3_restart_round", round_idx, 1);
      chk("t3_restart_rc", rc_out, exp_rc(1));
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t3_abort2_busy", busy, 0);

      // 4: start ignored at r=4 and in DONE
      hs_cnt = 0;
      done_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      chk("t4_round4", round_idx, 4);
      start = 1'b1; tick(); start = 1'b0;
      chk("t4_round5", round_idx, 5);
      for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
      chk("t4_done", done, 1);
      start = 1'b1; tick(); start = 1'b0;
      chk("t4_busy_after", busy, 0);
      chk("t4_valid_after", rc_valid, 0);
      tick();
      chk("t4_valid_idle", rc_valid, 0);
      chk("t4_hs_cnt", hs_cnt, 12);
      chk("t4_done_cnt", done_cnt, 1);

      // 5: asynchronous reset mid-cycle at r=7
      start = 1'b1; tick(); start = 1'b0;
      repeat (6) tick();
      chk("t5_round7", round_idx, 7);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_valid", rc_valid, 0);
      chk("t5_round", round_idx, 0);
      chk("t5_rc", rc_out, 0);
      chk("t5_busy", busy, 0);
      chk("t5_last", last_round, 0);
      #1;
      rst_n = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      chk("t5_restart_round", round_idx, 1);
      chk("t5_restart_rc", rc_out, exp_rc(1));
      chk("t5_restart_valid", rc_valid, 1);
      abort = 1'b1; tick(); abort = 1'b0;

      // 6a: NUM_ROUNDS = 1
      ready1 = 1'b1;
      start1 = 1'b1; tick(); start1 = 1'b0;
      chk("t6a_valid", valid1, 1);
      chk("t6a_round", round1, 1);
      chk("t6a_last", last1, 1);
      chk("t6a_rc", rc1, 128'ha7d3e671_00000000_00000000_00000000);
      tick();
      chk("t6a_done", done1, 1);
      chk("t6a_valid_off", valid1, 0);
      tick();
      chk("t6a_done_clr", done1, 0);
      chk("t6a_busy_clr", busy1, 0);

      // 6b: NUM_ROUNDS = 15
      ready15 = 1'b1;
      start15 = 1'b1; tick(); start15 = 1'b0;
      for (int r = 1; r <= 15; r++) begin
         chk($sformatf("t6b_round%0d", r), round15, r);
         chk($sformatf("t6b_rc%0d", r), rc15, exp_rc(r));
         chk($sformatf("t6b_last%0d", r), last15, (r == 15));
         tick();
      end
      chk("t6b_rc15_literal", exp_rc(15), 128'h6020088b_00000000_00000000_00000000);
      chk("t6b_done", done15, 1);
      chk("t6b_round0", round15, 0);
      chk("t6b_valid_off", valid15, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
